lsu: RTL and testbench

- Load/store unit: the pipeline stage directly downstream of the execute stage and upstream of writeback.
- Takes the execute-stage result (effective address, or pass-through ALU result) plus store data and the access type.
- Runs one data-memory transaction over a valid/ready request/response interface and hands an aligned, extended result to writeback.
- One outstanding access at most; non-memory ops pass through in one cycle.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_if.sv | 59 +++++
 rtl/lsu_align.sv | 62 ++++++
 rtl/lsu.sv | 126 ++++++++++++
 tb/tb_lsu.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU definitions: widths, RV32 funct3 access encodings, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package lsu_pkg;

    localparam int XLEN   = 32;
    localparam int STRB_W = XLEN / 8;

    // Load encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/lsu_if.sv
// Bundle of the LSU's execute-side, memory-side and writeback-side handshakes.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on every channel; slave = LSU view, master = environment view.
interface lsu_if;
    import lsu_pkg::*;

    // execute stage -> LSU
    logic              in_valid_i;
    logic              in_ready_o;
    logic              in_load_i;
    logic              in_store_i;
    logic [2:0]        in_funct3_i;
    logic [XLEN-1:0]   in_res_i;
    logic [XLEN-1:0]   in_wdata_i;

    // LSU -> data memory request
    logic              mem_req_valid_o;
    logic              mem_req_ready_i;
    logic              mem_req_we_o;
    logic [XLEN-1:0]   mem_req_addr_o;
    logic [XLEN-1:0]   mem_req_wdata_o;
    logic [STRB_W-1:0] mem_req_wstrb_o;

    // data memory -> LSU response
    logic              mem_rsp_valid_i;
    logic              mem_rsp_ready_o;
    logic [XLEN-1:0]   mem_rsp_rdata_i;
    logic              mem_rsp_err_i;

    // LSU -> writeback
    logic              out_valid_o;
    logic              out_ready_i;
    logic [XLEN-1:0]   out_data_o;
    logic              out_misalign_o;
    logic              out_fault_o;

    modport slave (
        input  in_valid_i, in_load_i, in_store_i, in_funct3_i, in_res_i, in_wdata_i,
        output in_ready_o,
        output mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o, mem_req_wstrb_o,
        input  mem_req_ready_i,
        input  mem_rsp_valid_i, mem_rsp_rdata_i, mem_rsp_err_i,
        output mem_rsp_ready_o,
        output out_valid_o, out_data_o, out_misalign_o, out_fault_o,
        input  out_ready_i
    );

    modport master (
        output in_valid_i, in_load_i, in_store_i, in_funct3_i, in_res_i, in_wdata_i,
        input  in_ready_o,
        input  mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o, mem_req_wstrb_o,
        output mem_req_ready_i,
        output mem_rsp_valid_i, mem_rsp_rdata_i, mem_rsp_err_i,
        input  mem_rsp_ready_o,
        input  out_valid_o, out_data_o, out_misalign_o, out_fault_o,
        output out_ready_i
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes/replicated data, load extract+extend, misalign/illegal flags.
// Latency: purely combinational.
// Backpressure: none (no state).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]        i_funct3,
    input  logic              i_store,
    input  logic [1:0]        i_off,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [XLEN-1:0]   i_rdata,
    output logic [STRB_W-1:0] o_wstrb,
    output logic [XLEN-1:0]   o_wdata,
    output logic [XLEN-1:0]   o_rdata,
    output logic              o_misalign,
    output logic              o_illegal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Halfword lanes only ever start at offset 0 or 2 once misaligned ops are filtered out.
    assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
    assign w_half = i_rdata[{i_off[1], 4'b0000} +: 16];

    // Decode access size/signedness into lane strobes, replicated write data and extended read data.
    always_comb begin
        o_wstrb    = '0;
        o_wdata    = i_wdata;
        o_rdata    = i_rdata;
        o_misalign = 1'b0;
        o_illegal  = 1'b0;
        case (i_funct3)
            F3_LB: begin
                o_wstrb = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_byte[7]}}, w_byte};
            end
            F3_LH: begin
                o_wstrb    = 4'b0011 << i_off;
                o_wdata    = {2{i_wdata[15:0]}};
                o_rdata    = {{16{w_half[15]}}, w_half};
                o_misalign = i_off[0];
            end
            F3_LW: begin
                o_wstrb    = 4'b1111;
                o_misalign = |i_off;
            end
            F3_LBU: begin
                o_rdata   = {24'd0, w_byte};
                o_illegal = i_store;
            end
            F3_LHU: begin
                o_rdata    = {16'd0, w_half};
                o_misalign = i_off[0];
                o_illegal  = i_store;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one memory access per op between execute and writeback.
// Latency: non-mem/rejected ops 1 cycle; loads/stores >=3 cycles (accept, REQ, WAIT, DONE).
// Backpressure: single op in flight; in_ready only in IDLE, results held until out_ready.
module lsu
    import lsu_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    lsu_if.slave bus
);

    state_t            r_state;
    state_t            w_next;

    logic [XLEN-1:0]   r_req_addr;
    logic              r_req_we;
    logic [STRB_W-1:0] r_req_wstrb;
    logic [XLEN-1:0]   r_req_wdata;
    logic [2:0]        r_funct3;
    logic [1:0]        r_off;
    logic [XLEN-1:0]   r_out_data;
    logic              r_out_misalign;
    logic              r_out_fault;

    logic [2:0]        w_funct3;
    logic [1:0]        w_off;
    logic [STRB_W-1:0] w_wstrb;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_rdata;
    logic              w_misalign;
    logic              w_illegal;
    logic              w_nomem;
    logic              w_both;
    logic              w_go_req;

    // The aligner sees the incoming op while IDLE and the captured op afterwards,
    // so one instance serves both the store setup and the load extraction.
    assign w_funct3 = (r_state == ST_IDLE) ? bus.in_funct3_i   : r_funct3;
    assign w_off    = (r_state == ST_IDLE) ? bus.in_res_i[1:0] : r_off;

    lsu_align u_align (
        .i_funct3   (w_funct3),
        .i_store    (bus.in_store_i),
        .i_off      (w_off),
        .i_wdata    (bus.in_wdata_i),
        .i_rdata    (bus.mem_rsp_rdata_i),
        .o_wstrb    (w_wstrb),
        .o_wdata    (w_wdata),
        .o_rdata    (w_rdata),
        .o_misalign (w_misalign),
        .o_illegal  (w_illegal)
    );

    assign w_nomem  = !bus.in_load_i && !bus.in_store_i;
    assign w_both   = bus.in_load_i && bus.in_store_i;
    assign w_go_req = !w_nomem && !w_both && !w_illegal && !w_misalign;

    assign bus.in_ready_o      = (r_state == ST_IDLE);
    assign bus.mem_req_valid_o = (r_state == ST_REQ);
    assign bus.mem_rsp_ready_o = (r_state == ST_WAIT);
    assign bus.out_valid_o     = (r_state == ST_DONE);
    assign bus.mem_req_we_o    = r_req_we;
    assign bus.mem_req_addr_o  = r_req_addr;
    assign bus.mem_req_wdata_o = r_req_wdata;
    assign bus.mem_req_wstrb_o = r_req_wstrb;
    assign bus.out_data_o      = r_out_data;
    assign bus.out_misalign_o  = r_out_misalign;
    assign bus.out_fault_o     = r_out_fault;

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Next-state: only valid ops that pass all checks touch memory.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid_i)      w_next = w_go_req ? ST_REQ : ST_DONE;
            ST_REQ:  if (bus.mem_req_ready_i) w_next = ST_WAIT;
            ST_WAIT: if (bus.mem_rsp_valid_i) w_next = ST_DONE;
            ST_DONE: if (bus.out_ready_i)     w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Capture the op on acceptance and the result on response; held otherwise for stability.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_req_addr     <= '0;
            r_req_we       <= 1'b0;
            r_req_wstrb    <= '0;
            r_req_wdata    <= '0;
            r_funct3       <= '0;
            r_off          <= '0;
            r_out_data     <= '0;
            r_out_misalign <= 1'b0;
            r_out_fault    <= 1'b0;
        end else if (r_state == ST_IDLE && bus.in_valid_i) begin
            r_out_misalign <= 1'b0;
            r_out_fault    <= 1'b0;
            r_out_data     <= '0;
            if (w_nomem) begin
                r_out_data <= bus.in_res_i;
            end else if (w_both || w_illegal) begin
                r_out_fault <= 1'b1;
            end else if (w_misalign) begin
                r_out_misalign <= 1'b1;
                r_out_data     <= bus.in_res_i;
            end else begin
                r_req_addr  <= {bus.in_res_i[XLEN-1:2], 2'b00};
                r_req_we    <= bus.in_store_i;
                r_req_wstrb <= bus.in_store_i ? w_wstrb : '0;
                r_req_wdata <= bus.in_store_i ? w_wdata : '0;
                r_funct3    <= bus.in_funct3_i;
                r_off       <= bus.in_res_i[1:0];
            end
        end else if (r_state == ST_WAIT && bus.mem_rsp_valid_i) begin
            r_out_fault    <= bus.mem_rsp_err_i;
            r_out_misalign <= 1'b0;
            r_out_data     <= (bus.mem_rsp_err_i || r_req_we) ? '0 : w_rdata;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu: pass-through, load extension, store lanes,
// rejected ops, backpressure, bus error and reset in the middle of an access.
// Memory and writeback sides are driven by the bench's own tasks.
module tb_lsu;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks   = 0;
    int failures = 0;
    int n_req_hs  = 0;
    int n_req_cyc = 0;
    int n_out_hs  = 0;

    logic [31:0] rec_addr, rec_wdata, rec_data;
    logic [3:0]  rec_wstrb;
    logic        rec_we, rec_fault, rec_mis;

    lsu_if bus();

    lsu dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Transfer counters for "single transfer" and "no request" checks.
    always @(posedge clk) begin
        if (bus.mem_req_valid_o && bus.mem_req_ready_i) n_req_hs <= n_req_hs + 1;
        if (bus.mem_req_valid_o)                        n_req_cyc <= n_req_cyc + 1;
        if (bus.out_valid_o && bus.out_ready_i)         n_out_hs <= n_out_hs + 1;
    end

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] res, input logic [31:0] wd);
        bus.in_load_i   = ld;
        bus.in_store_i  = st;
        bus.in_funct3_i = f3;
        bus.in_res_i    = res;
        bus.in_wdata_i  = wd;
        bus.in_valid_i  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid_i  = 1'b0;
    endtask

    // Full memory transaction with optional request/output stall cycles.
    task automatic run_mem(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] res, input logic [31:0] wd,
                           input logic [31:0] rdata, input logic err,
                           input int req_stall, input int out_stall, input string name);
        int n;
        int req0;
        int out0;
        req0 = n_req_hs;
        out0 = n_out_hs;
        bus.mem_req_ready_i = (req_stall == 0);
        issue(ld, st, f3, res, wd);
        n = 0;
        while (!bus.mem_req_valid_o && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (bus.mem_req_valid_o !== 1'b1) begin
            $display("FAIL %s req_valid_timeout got=%b exp=1", name, bus.mem_req_valid_o); failures++;
        end
        rec_addr  = bus.mem_req_addr_o;
        rec_we    = bus.mem_req_we_o;
        rec_wstrb = bus.mem_req_wstrb_o;
        rec_wdata = bus.mem_req_wdata_o;
        for (int i = 0; i < req_stall; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.mem_req_valid_o !== 1'b1 || bus.mem_req_addr_o !== rec_addr ||
                bus.mem_req_we_o !== rec_we || bus.mem_req_wstrb_o !== rec_wstrb ||
                bus.mem_req_wdata_o !== rec_wdata || bus.in_ready_o !== 1'b0) begin
                $display("FAIL %s req_stable cyc=%0d got v=%b a=%h in_rdy=%b exp v=1 a=%h in_rdy=0",
                         name, i, bus.mem_req_valid_o, bus.mem_req_addr_o, bus.in_ready_o, rec_addr);
                failures++;
            end
        end
        bus.mem_req_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.mem_req_ready_i = 1'b0;
        n = 0;
        while (!bus.mem_rsp_ready_o && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (bus.mem_rsp_ready_o !== 1'b1) begin
            $display("FAIL %s rsp_ready_timeout got=%b exp=1", name, bus.mem_rsp_ready_o); failures++;
        end
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_rdata_i = rdata;
        bus.mem_rsp_err_i   = err;
        @(posedge clk); #1;
        bus.mem_rsp_valid_i = 1'b0;
        bus.mem_rsp_err_i   = 1'b0;
        n = 0;
        while (!bus.out_valid_o && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (bus.out_valid_o !== 1'b1) begin
            $display("FAIL %s out_valid_timeout got=%b exp=1", name, bus.out_valid_o); failures++;
        end
        rec_data  = bus.out_data_o;
        rec_fault = bus.out_fault_o;
        rec_mis   = bus.out_misalign_o;
        for (int i = 0; i < out_stall; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== rec_data ||
                bus.out_fault_o !== rec_fault || bus.out_misalign_o !== rec_mis ||
                bus.in_ready_o !== 1'b0) begin
                $display("FAIL %s out_stable cyc=%0d got v=%b d=%h in_rdy=%b exp v=1 d=%h in_rdy=0",
                         name, i, bus.out_valid_o, bus.out_data_o, bus.in_ready_o, rec_data);
                failures++;
            end
        end
        bus.out_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.out_ready_i = 1'b0;
        checks++;
        if (n_req_hs - req0 != 1 || n_out_hs - out0 != 1) begin
            $display("FAIL %s transfers got req=%0d out=%0d exp req=1 out=1",
                     name, n_req_hs - req0, n_out_hs - out0);
            failures++;
        end
        checks++;
        if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin
            $display("FAIL %s back_to_idle got in_rdy=%b out_v=%b exp in_rdy=1 out_v=0",
                     name, bus.in_ready_o, bus.out_valid_o);
            failures++;
        end
    endtask

    // Op that must finish without touching memory, result valid one cycle after acceptance.
    task automatic run_nomem(input logic ld, input logic st, input logic [2:0] f3,
                             input logic [31:0] res, input string name);
        int cyc0;
        cyc0 = n_req_cyc;
        issue(ld, st, f3, res, 32'hFFFF_FFFF);
        checks++;
        if (bus.out_valid_o !== 1'b1) begin
            $display("FAIL %s out_valid_latency got=%b exp=1", name, bus.out_valid_o); failures++;
        end
        rec_data  = bus.out_data_o;
        rec_fault = bus.out_fault_o;
        rec_mis   = bus.out_misalign_o;
        bus.out_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.out_ready_i = 1'b0;
        checks++;
        if (n_req_cyc != cyc0 || bus.in_ready_o !== 1'b1) begin
            $display("FAIL %s no_request got req_cycles=%0d in_rdy=%b exp req_cycles=0 in_rdy=1",
                     name, n_req_cyc - cyc0, bus.in_ready_o);
            failures++;
        end
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0 ||
            bus.mem_req_valid_o !== 1'b0 || bus.mem_rsp_ready_o !== 1'b0) begin
            $display("FAIL reset_handshake got in_rdy=%b out_v=%b req_v=%b rsp_rdy=%b exp 1 0 0 0",
                     bus.in_ready_o, bus.out_valid_o, bus.mem_req_valid_o, bus.mem_rsp_ready_o);
            failures++;
        end
        checks++;
        if (bus.mem_req_addr_o !== 32'h0 || bus.mem_req_wdata_o !== 32'h0 ||
            bus.mem_req_wstrb_o !== 4'h0 || bus.mem_req_we_o !== 1'b0) begin
            $display("FAIL reset_req_fields got a=%h d=%h s=%h we=%b exp all 0",
                     bus.mem_req_addr_o, bus.mem_req_wdata_o, bus.mem_req_wstrb_o, bus.mem_req_we_o);
            failures++;
        end
        checks++;
        if (bus.out_data_o !== 32'h0 || bus.out_fault_o !== 1'b0 || bus.out_misalign_o !== 1'b0) begin
            $display("FAIL reset_out got d=%h f=%b m=%b exp 0 0 0",
                     bus.out_data_o, bus.out_fault_o, bus.out_misalign_o);
            failures++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_passthrough;
        run_nomem(1'b0, 1'b0, 3'b000, 32'h0000_1234, "alu");
        checks++;
        if (rec_data !== 32'h0000_1234 || rec_fault !== 1'b0 || rec_mis !== 1'b0) begin
            $display("FAIL alu_result got d=%h f=%b m=%b exp d=00001234 f=0 m=0", rec_data, rec_fault, rec_mis);
            failures++;
        end
    endtask

    task automatic test_load_extend;
        run_mem(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80AB_CDEF, 1'b0, 0, 0, "lb");
        checks++;
        if (rec_addr !== 32'h8000_0000 || rec_wstrb !== 4'h0 || rec_we !== 1'b0) begin
            $display("FAIL lb_req got a=%h s=%h we=%b exp a=80000000 s=0 we=0", rec_addr, rec_wstrb, rec_we);
            failures++;
        end
        checks++;
        if (rec_data !== 32'hFFFF_FF80) begin
            $display("FAIL lb_data got=%h exp=ffffff80", rec_data); failures++;
        end
        run_mem(1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h80AB_CDEF, 1'b0, 0, 0, "lbu");
        checks++;
        if (rec_data !== 32'h0000_0080) begin
            $display("FAIL lbu_data got=%h exp=00000080", rec_data); failures++;
        end
        run_mem(1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h80AB_CDEF, 1'b0, 0, 0, "lh");
        checks++;
        if (rec_data !== 32'hFFFF_80AB) begin
            $display("FAIL lh_data got=%h exp=ffff80ab", rec_data); failures++;
        end
        run_mem(1'b1, 1'b0, 3'b101, 32'h8000_0000, 32'h0, 32'h80AB_CDEF, 1'b0, 0, 0, "lhu");
        checks++;
        if (rec_data !== 32'h0000_CDEF) begin
            $display("FAIL lhu_data got=%h exp=0000cdef", rec_data); failures++;
        end
    endtask

    task automatic test_store_lanes;
        run_mem(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 0, 0, "sh");
        checks++;
        if (rec_we !== 1'b1 || rec_addr !== 32'h0000_0100 || rec_wstrb !== 4'b1100 ||
            rec_wdata !== 32'hBEEF_BEEF) begin
            $display("FAIL sh_req got we=%b a=%h s=%b d=%h exp we=1 a=00000100 s=1100 d=beefbeef",
                     rec_we, rec_addr, rec_wstrb, rec_wdata);
            failures++;
        end
        checks++;
        if (rec_data !== 32'h0 || rec_fault !== 1'b0) begin
            $display("FAIL sh_out got d=%h f=%b exp d=0 f=0", rec_data, rec_fault); failures++;
        end
        run_mem(1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 32'h0, 1'b0, 0, 0, "sb");
        checks++;
        if (rec_addr !== 32'h0000_0200 || rec_wstrb !== 4'b0010 || rec_wdata !== 32'hA5A5_A5A5) begin
            $display("FAIL sb_req got a=%h s=%b d=%h exp a=00000200 s=0010 d=a5a5a5a5",
                     rec_addr, rec_wstrb, rec_wdata);
            failures++;
        end
        run_mem(1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'h0123_4567, 32'h0, 1'b0, 0, 0, "sw");
        checks++;
        if (rec_addr !== 32'h0000_0300 || rec_wstrb !== 4'b1111 || rec_wdata !== 32'h0123_4567) begin
            $display("FAIL sw_req got a=%h s=%b d=%h exp a=00000300 s=1111 d=01234567",
                     rec_addr, rec_wstrb, rec_wdata);
            failures++;
        end
    endtask

    task automatic test_rejected_ops;
        run_nomem(1'b1, 1'b0, 3'b010, 32'h0000_0101, "lw_misalign");
        checks++;
        if (rec_mis !== 1'b1 || rec_fault !== 1'b0 || rec_data !== 32'h0000_0101) begin
            $display("FAIL lw_misalign got m=%b f=%b d=%h exp m=1 f=0 d=00000101", rec_mis, rec_fault, rec_data);
            failures++;
        end
        run_nomem(1'b0, 1'b1, 3'b001, 32'h0000_0103, "sh_misalign");
        checks++;
        if (rec_mis !== 1'b1 || rec_fault !== 1'b0) begin
            $display("FAIL sh_misalign got m=%b f=%b exp m=1 f=0", rec_mis, rec_fault); failures++;
        end
        run_nomem(1'b1, 1'b0, 3'b011, 32'h0000_0100, "ld_f3_011");
        checks++;
        if (rec_fault !== 1'b1 || rec_mis !== 1'b0) begin
            $display("FAIL ld_f3_011 got f=%b m=%b exp f=1 m=0", rec_fault, rec_mis); failures++;
        end
        run_nomem(1'b0, 1'b1, 3'b100, 32'h0000_0100, "st_f3_100");
        checks++;
        if (rec_fault !== 1'b1) begin
            $display("FAIL st_f3_100 got f=%b exp f=1", rec_fault); failures++;
        end
        run_nomem(1'b1, 1'b1, 3'b010, 32'h0000_0100, "ld_and_st");
        checks++;
        if (rec_fault !== 1'b1) begin
            $display("FAIL ld_and_st got f=%b exp f=1", rec_fault); failures++;
        end
    endtask

    task automatic test_backpressure;
        run_mem(1'b1, 1'b0, 3'b001, 32'h0000_0042, 32'h0, 32'h9876_5432, 1'b0, 3, 2, "bp_lh");
        checks++;
        if (rec_addr !== 32'h0000_0040 || rec_data !== 32'hFFFF_9876) begin
            $display("FAIL bp_lh got a=%h d=%h exp a=00000040 d=ffff9876", rec_addr, rec_data); failures++;
        end
    endtask

    task automatic test_bus_error;
        run_mem(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'h5555_5555, 1'b1, 0, 0, "buserr");
        checks++;
        if (rec_fault !== 1'b1 || rec_data !== 32'h0) begin
            $display("FAIL buserr got f=%b d=%h exp f=1 d=0", rec_fault, rec_data); failures++;
        end
    endtask

    task automatic test_reset_in_wait;
        int n;
        bus.mem_req_ready_i = 1'b1;
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0);
        @(posedge clk); #1;
        bus.mem_req_ready_i = 1'b0;
        checks++;
        if (bus.mem_rsp_ready_o !== 1'b1) begin
            $display("FAIL rst_wait_reach got rsp_rdy=%b exp=1", bus.mem_rsp_ready_o); failures++;
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (bus.in_ready_o !== 1'b1 || bus.mem_rsp_ready_o !== 1'b0 || bus.mem_req_valid_o !== 1'b0 ||
            bus.out_valid_o !== 1'b0 || bus.mem_req_addr_o !== 32'h0 || bus.out_data_o !== 32'h0) begin
            $display("FAIL rst_wait_async got in_rdy=%b rsp_rdy=%b req_v=%b out_v=%b a=%h d=%h exp 1 0 0 0 0 0",
                     bus.in_ready_o, bus.mem_rsp_ready_o, bus.mem_req_valid_o, bus.out_valid_o,
                     bus.mem_req_addr_o, bus.out_data_o);
            failures++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n = 0;
        run_mem(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h1234_5678, 1'b0, 0, 0, "post_rst_lw");
        checks++;
        if (rec_data !== 32'h1234_5678 || rec_fault !== 1'b0 || rec_addr !== 32'h0000_0200) begin
            $display("FAIL post_rst_lw got d=%h f=%b a=%h exp d=12345678 f=0 a=00000200",
                     rec_data, rec_fault, rec_addr);
            failures++;
        end
    endtask

    initial begin
        bus.in_valid_i      = 1'b0;
        bus.in_load_i       = 1'b0;
        bus.in_store_i      = 1'b0;
        bus.in_funct3_i     = 3'b000;
        bus.in_res_i        = 32'h0;
        bus.in_wdata_i      = 32'h0;
        bus.mem_req_ready_i = 1'b0;
        bus.mem_rsp_valid_i = 1'b0;
        bus.mem_rsp_rdata_i = 32'h0;
        bus.mem_rsp_err_i   = 1'b0;
        bus.out_ready_i     = 1'b0;

        test_reset();
        test_passthrough();
        test_load_extend();
        test_store_lanes();
        test_rejected_ops();
        test_backpressure();
        test_bus_error();
        test_reset_in_wait();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
